idecoder_pipe: RTL and testbench
================================

// Module: idecoder_pipe
// PURPOSE
// Registered, flow-controlled RV32I(+M) instruction decode stage for copperv.
// - Sits between fetch and execute.
// - Decodes each accepted instruction the cycle it is accepted and queues the result in a DEPTH-entry FIFO.
// - Provides a valid/ready handshake on both sides, a flush input and an illegal-instruction flag.
// - Undefined encodings produce a defined result instead of X.
// PARAMETERS
// inst_width       32  instruction width
// pc_width         32  width of the PC carried alongside the instruction
// imm_width        32  decoded immediate width
// reg_width        5   register index width
// inst_type_width  4   inst_type width; codes come from copperv_pkg
// funct_width      5   funct width; codes come from copperv_pkg
// DEPTH            2   FIFO entries; power of two, >=2
// ENABLE_M         1   1: decode the M extension (funct7=1 on opcode_int_reg); 0: treat it as illegal
// PORTS
// clk        in   1               clock, rising edge
// rst        in   1               asynchronous reset, active low
// flush      in   1               discard all queued entries (branch/trap redirect)
// in_valid   in   1               fetch presents inst/in_pc
// in_ready   out  1               stage can accept
// inst       in   inst_width      raw instruction
// in_pc      in   pc_width        PC of inst
// out_valid  out  1               head entry valid
// out_ready  in   1               execute consumes the head entry
// out_pc     out  pc_width        PC of the head entry
// inst_type  out  inst_type_width decoded class
// funct      out  funct_width     ALU/branch/mem function
// imm        out  imm_width       sign- or zero-extended immediate
// rd/rs1/rs2 out  reg_width       register indices; 0 when the format has no such field
// is_m       out  1               M-extension operation
// m_op       out  3               funct3 of the M operation (0=MUL..7=REMU); 0 when is_m=0
// illegal    out  1               undefined encoding
// BEHAVIOUR
// - Reset (rst=0, async):
//   - FIFO pointers and count clear.
//   - out_valid=0; in_ready=1 after release.
//   - Every data output reads 0 while out_valid=0; the stored decode fields are cleared.
// - Push: in_valid & in_ready at a rising edge. Pop: out_valid & out_ready at a rising edge.
// - in_ready = (count<DEPTH) & !flush.
//   - in_ready depends on the registered count only, so a pop in the same cycle does NOT free a slot when the FIFO is full.
// - out_valid = (count!=0). Outputs are driven from the head entry, registered.
// - Latency: an instruction accepted at edge N is visible at the outputs after edge N. Throughput is 1/cycle.
// - Ordering: strict FIFO. Simultaneous push and pop with 0<count<DEPTH keeps count unchanged.
// - Pointers wrap modulo DEPTH.
// - flush=1: the next edge sets count=0 and resets both pointers. Any push that cycle is blocked (in_ready=0), and a pop is ignored.
// - Decoding is combinational on inst at push time; only the results are stored.
//   - U-type (lui/auipc): imm = {inst[31:12],12'b0}; rd.
//   - J-type (jal): imm = sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}; rd.
//   - I-type (jalr/load/int_imm): imm = sign-extended inst[31:20]; rd, rs1.
//   - S-type (store): imm = sign-extended {inst[31:25],inst[11:7]}; rs1, rs2.
//   - B-type (branch): imm = sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}; rs1, rs2.
//   - R-type (int_reg): rd, rs1, rs2; imm=0.
//   - Shift immediates (funct3 1 or 5 on opcode_int_imm): imm = zero-extended inst[24:20].
//     - inst[31:25] must be 0, or 32 for SRAI only; otherwise illegal.
//   - opcode_int_reg with funct7=1 and ENABLE_M=1: is_m=1, m_op=funct3, funct=0.
//   - funct mapping: copperv_pkg funct_* codes, identical to the RV32I base decode.
// - illegal=1 for any of:
//   - unlisted opcode
//   - branch funct3 of 2 or 3
//   - store funct3>2
//   - load funct3 of 3, 6 or 7
//   - int_reg {funct7,funct3} outside the RV32I/M set
//   - funct7=1 with ENABLE_M=0
//   - bad shift-immediate funct7
// - An illegal entry still queues and forces inst_type=0, funct=0, imm=0, rd=rs1=rs2=0 and is_m=0; out_pc is kept for trap reporting.
// - fence: inst_type=inst_type_fence; all other fields 0.
// TESTING
// 1. addi x1,x0,5 (0x00500093), in_pc=0x100 -> one cycle later: out_valid=1, inst_type_int_imm, funct_add, rd=1, rs1=0, imm=5, out_pc=0x100, illegal=0.
// 2. srai x2,x3,4 (0x4041D113) -> funct_sra, imm=4, rd=2, rs1=3. Same with inst[31:25]=0x10 -> illegal=1, all fields 0.
// 3. mul x5,x6,x7 (0x027302B3) -> ENABLE_M=1: is_m=1, m_op=0, rd=5, rs1=6, rs2=7. ENABLE_M=0: illegal=1.
// 4. DEPTH=2, out_ready=0, stream lui x1,0x12345 (0x123450B7) then addi -> in_ready=0 after two pushes.
//    Then out_ready=1 -> lui (imm=0x12345000, rd=1) pops first, then addi.
//    Pop while full with in_valid=1 -> no push that cycle.
// 5. Two entries queued, flush=1 with in_valid=1 -> in_ready=0 that cycle; next cycle out_valid=0 and count=0.
//    The following push then appears alone.
// 6. rst low mid-stream with two entries queued -> out_valid=0 immediately (async), all data outputs 0, and no stale entry appears after release.
//    Also: 0x0000007F -> illegal=1 with correct out_pc.

Source files
------------

// File: rtl/idecoder_pipe.sv
// RV32I(+M) decode stage: decodes each accepted instruction and queues the
// result in a small FIFO between fetch and execute, with flush and illegal flag.
module idecoder_pipe #(
  parameter int inst_width      = 32,
  parameter int pc_width        = 32,
  parameter int imm_width       = 32,
  parameter int reg_width       = 5,
  parameter int inst_type_width = 4,
  parameter int funct_width     = 5,
  parameter int DEPTH           = 2,
  parameter int ENABLE_M        = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [inst_width-1:0]      inst,
  input  logic [pc_width-1:0]        in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [pc_width-1:0]        out_pc,
  output logic [inst_type_width-1:0] inst_type,
  output logic [funct_width-1:0]     funct,
  output logic [imm_width-1:0]       imm,
  output logic [reg_width-1:0]       rd,
  output logic [reg_width-1:0]       rs1,
  output logic [reg_width-1:0]       rs2,
  output logic                       is_m,
  output logic [2:0]                 m_op,
  output logic                       illegal
);

  localparam logic [inst_type_width-1:0] inst_type_lui     = inst_type_width'(1);
  localparam logic [inst_type_width-1:0] inst_type_auipc   = inst_type_width'(2);
  localparam logic [inst_type_width-1:0] inst_type_jal     = inst_type_width'(3);
  localparam logic [inst_type_width-1:0] inst_type_jalr    = inst_type_width'(4);
  localparam logic [inst_type_width-1:0] inst_type_branch  = inst_type_width'(5);
  localparam logic [inst_type_width-1:0] inst_type_load    = inst_type_width'(6);
  localparam logic [inst_type_width-1:0] inst_type_store   = inst_type_width'(7);
  localparam logic [inst_type_width-1:0] inst_type_int_imm = inst_type_width'(8);
  localparam logic [inst_type_width-1:0] inst_type_int_reg = inst_type_width'(9);
  localparam logic [inst_type_width-1:0] inst_type_fence   = inst_type_width'(10);

  localparam logic [funct_width-1:0] funct_add       = funct_width'(1);
  localparam logic [funct_width-1:0] funct_sub       = funct_width'(2);
  localparam logic [funct_width-1:0] funct_sll       = funct_width'(3);
  localparam logic [funct_width-1:0] funct_slt       = funct_width'(4);
  localparam logic [funct_width-1:0] funct_sltu      = funct_width'(5);
  localparam logic [funct_width-1:0] funct_xor       = funct_width'(6);
  localparam logic [funct_width-1:0] funct_srl       = funct_width'(7);
  localparam logic [funct_width-1:0] funct_sra       = funct_width'(8);
  localparam logic [funct_width-1:0] funct_or        = funct_width'(9);
  localparam logic [funct_width-1:0] funct_and       = funct_width'(10);
  localparam logic [funct_width-1:0] funct_eq        = funct_width'(11);
  localparam logic [funct_width-1:0] funct_neq       = funct_width'(12);
  localparam logic [funct_width-1:0] funct_lt        = funct_width'(13);
  localparam logic [funct_width-1:0] funct_gte       = funct_width'(14);
  localparam logic [funct_width-1:0] funct_ltu       = funct_width'(15);
  localparam logic [funct_width-1:0] funct_gteu      = funct_width'(16);
  localparam logic [funct_width-1:0] funct_mem_byte  = funct_width'(17);
  localparam logic [funct_width-1:0] funct_mem_half  = funct_width'(18);
  localparam logic [funct_width-1:0] funct_mem_word  = funct_width'(19);
  localparam logic [funct_width-1:0] funct_mem_byteu = funct_width'(20);
  localparam logic [funct_width-1:0] funct_mem_halfu = funct_width'(21);

  localparam logic [6:0] op_lui     = 7'b0110111;
  localparam logic [6:0] op_auipc   = 7'b0010111;
  localparam logic [6:0] op_jal     = 7'b1101111;
  localparam logic [6:0] op_jalr    = 7'b1100111;
  localparam logic [6:0] op_branch  = 7'b1100011;
  localparam logic [6:0] op_load    = 7'b0000011;
  localparam logic [6:0] op_store   = 7'b0100011;
  localparam logic [6:0] op_int_imm = 7'b0010011;
  localparam logic [6:0] op_int_reg = 7'b0110011;
  localparam logic [6:0] op_fence   = 7'b0001111;

  localparam int ptr_width = $clog2(DEPTH);
  localparam int cnt_width = ptr_width + 1;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_shamt;

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign funct7    = inst[31:25];
  assign imm_i     = {{20{inst[31]}}, inst[31:20]};
  assign imm_s     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u     = {inst[31:12], 12'b0};
  assign imm_j     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_shamt = {27'b0, inst[24:20]};

  logic [inst_type_width-1:0] dec_type;
  logic [funct_width-1:0]     dec_funct;
  logic [31:0]                dec_imm;
  logic [4:0]                 dec_rd;
  logic [4:0]                 dec_rs1;
  logic [4:0]                 dec_rs2;
  logic                       dec_is_m;
  logic [2:0]                 dec_m_op;
  logic                       dec_illegal;

  always_comb begin
    dec_type    = '0;
    dec_funct   = '0;
    dec_imm     = '0;
    dec_rd      = '0;
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_is_m    = 1'b0;
    dec_m_op    = '0;
    dec_illegal = 1'b0;
    case (opcode)
      op_lui: begin
        dec_type = inst_type_lui;
        dec_imm  = imm_u;
        dec_rd   = inst[11:7];
      end
      op_auipc: begin
        dec_type = inst_type_auipc;
        dec_imm  = imm_u;
        dec_rd   = inst[11:7];
      end
      op_jal: begin
        dec_type = inst_type_jal;
        dec_imm  = imm_j;
        dec_rd   = inst[11:7];
      end
      op_jalr: begin
        dec_type = inst_type_jalr;
        dec_imm  = imm_i;
        dec_rd   = inst[11:7];
        dec_rs1  = inst[19:15];
      end
      op_branch: begin
        dec_type = inst_type_branch;
        dec_imm  = imm_b;
        dec_rs1  = inst[19:15];
        dec_rs2  = inst[24:20];
        case (funct3)
          3'd0:    dec_funct = funct_eq;
          3'd1:    dec_funct = funct_neq;
          3'd4:    dec_funct = funct_lt;
          3'd5:    dec_funct = funct_gte;
          3'd6:    dec_funct = funct_ltu;
          3'd7:    dec_funct = funct_gteu;
          default: dec_illegal = 1'b1;
        endcase
      end
      op_load: begin
        dec_type = inst_type_load;
        dec_imm  = imm_i;
        dec_rd   = inst[11:7];
        dec_rs1  = inst[19:15];
        case (funct3)
          3'd0:    dec_funct = funct_mem_byte;
          3'd1:    dec_funct = funct_mem_half;
          3'd2:    dec_funct = funct_mem_word;
          3'd4:    dec_funct = funct_mem_byteu;
          3'd5:    dec_funct = funct_mem_halfu;
          default: dec_illegal = 1'b1;
        endcase
      end
      op_store: begin
        dec_type = inst_type_store;
        dec_imm  = imm_s;
        dec_rs1  = inst[19:15];
        dec_rs2  = inst[24:20];
        case (funct3)
          3'd0:    dec_funct = funct_mem_byte;
          3'd1:    dec_funct = funct_mem_half;
          3'd2:    dec_funct = funct_mem_word;
          default: dec_illegal = 1'b1;
        endcase
      end
      op_int_imm: begin
        dec_type = inst_type_int_imm;
        dec_imm  = imm_i;
        dec_rd   = inst[11:7];
        dec_rs1  = inst[19:15];
        case (funct3)
          3'd0: dec_funct = funct_add;
          3'd2: dec_funct = funct_slt;
          3'd3: dec_funct = funct_sltu;
          3'd4: dec_funct = funct_xor;
          3'd6: dec_funct = funct_or;
          3'd7: dec_funct = funct_and;
          3'd1: begin
            dec_imm   = imm_shamt;
            dec_funct = funct_sll;
            if (funct7 != 7'h00) dec_illegal = 1'b1;
          end
          default: begin
            // funct3=5: the upper immediate bits select logical vs arithmetic shift
            dec_imm = imm_shamt;
            if (funct7 == 7'h00)      dec_funct   = funct_srl;
            else if (funct7 == 7'h20) dec_funct   = funct_sra;
            else                      dec_illegal = 1'b1;
          end
        endcase
      end
      op_int_reg: begin
        dec_type = inst_type_int_reg;
        dec_rd   = inst[11:7];
        dec_rs1  = inst[19:15];
        dec_rs2  = inst[24:20];
        if (funct7 == 7'h01) begin
          if (ENABLE_M != 0) begin
            dec_is_m = 1'b1;
            dec_m_op = funct3;
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          case ({funct7, funct3})
            {7'h00, 3'd0}: dec_funct = funct_add;
            {7'h20, 3'd0}: dec_funct = funct_sub;
            {7'h00, 3'd1}: dec_funct = funct_sll;
            {7'h00, 3'd2}: dec_funct = funct_slt;
            {7'h00, 3'd3}: dec_funct = funct_sltu;
            {7'h00, 3'd4}: dec_funct = funct_xor;
            {7'h00, 3'd5}: dec_funct = funct_srl;
            {7'h20, 3'd5}: dec_funct = funct_sra;
            {7'h00, 3'd6}: dec_funct = funct_or;
            {7'h00, 3'd7}: dec_funct = funct_and;
            default:       dec_illegal = 1'b1;
          endcase
        end
      end
      op_fence: dec_type = inst_type_fence;
      default:  dec_illegal = 1'b1;
    endcase

    // Illegal entries carry only the flag (and the PC, stored separately).
    if (dec_illegal) begin
      dec_type  = '0;
      dec_funct = '0;
      dec_imm   = '0;
      dec_rd    = '0;
      dec_rs1   = '0;
      dec_rs2   = '0;
      dec_is_m  = 1'b0;
      dec_m_op  = '0;
    end
  end

  logic [pc_width-1:0]        pc_q      [DEPTH];
  logic [inst_type_width-1:0] type_q    [DEPTH];
  logic [funct_width-1:0]     funct_q   [DEPTH];
  logic [imm_width-1:0]       imm_q     [DEPTH];
  logic [reg_width-1:0]       rd_q      [DEPTH];
  logic [reg_width-1:0]       rs1_q     [DEPTH];
  logic [reg_width-1:0]       rs2_q     [DEPTH];
  logic                       is_m_q    [DEPTH];
  logic [2:0]                 m_op_q    [DEPTH];
  logic                       illegal_q [DEPTH];

  logic [ptr_width-1:0] wr_ptr;
  logic [ptr_width-1:0] rd_ptr;
  logic [cnt_width-1:0] count;
  logic                 push;
  logic                 pop;

  // Readiness looks only at the registered count, so a full FIFO stays closed
  // even when the head is being consumed in the same cycle.
  assign in_ready  = (count < cnt_width'(DEPTH)) & ~flush;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]      <= '0;
        type_q[i]    <= '0;
        funct_q[i]   <= '0;
        imm_q[i]     <= '0;
        rd_q[i]      <= '0;
        rs1_q[i]     <= '0;
        rs2_q[i]     <= '0;
        is_m_q[i]    <= 1'b0;
        m_op_q[i]    <= '0;
        illegal_q[i] <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]      <= in_pc;
        type_q[wr_ptr]    <= dec_type;
        funct_q[wr_ptr]   <= dec_funct;
        imm_q[wr_ptr]     <= imm_width'(dec_imm);
        rd_q[wr_ptr]      <= reg_width'(dec_rd);
        rs1_q[wr_ptr]     <= reg_width'(dec_rs1);
        rs2_q[wr_ptr]     <= reg_width'(dec_rs2);
        is_m_q[wr_ptr]    <= dec_is_m;
        m_op_q[wr_ptr]    <= dec_m_op;
        illegal_q[wr_ptr] <= dec_illegal;
        wr_ptr            <= wr_ptr + ptr_width'(1);
      end
      if (pop) rd_ptr <= rd_ptr + ptr_width'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_width'(1);
        2'b01:   count <= count - cnt_width'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    out_pc    = '0;
    inst_type = '0;
    funct     = '0;
    imm       = '0;
    rd        = '0;
    rs1       = '0;
    rs2       = '0;
    is_m      = 1'b0;
    m_op      = '0;
    illegal   = 1'b0;
    if (out_valid) begin
      out_pc    = pc_q[rd_ptr];
      inst_type = type_q[rd_ptr];
      funct     = funct_q[rd_ptr];
      imm       = imm_q[rd_ptr];
      rd        = rd_q[rd_ptr];
      rs1       = rs1_q[rd_ptr];
      rs2       = rs2_q[rd_ptr];
      is_m      = is_m_q[rd_ptr];
      m_op      = m_op_q[rd_ptr];
      illegal   = illegal_q[rd_ptr];
    end
  end

endmodule

// File: tb/tb_idecoder_pipe.sv
// Bench for idecoder_pipe: directed scenarios plus a randomized run against a
// queue-based reference model; two instances cover ENABLE_M=1 and ENABLE_M=0.
module tb_idecoder_pipe;

  localparam int DEPTH = 2;

  localparam logic [3:0] T_LUI = 4'd1, T_AUIPC = 4'd2, T_JAL = 4'd3, T_JALR = 4'd4,
                         T_BRANCH = 4'd5, T_LOAD = 4'd6, T_STORE = 4'd7,
                         T_INT_IMM = 4'd8, T_INT_REG = 4'd9, T_FENCE = 4'd10;
  localparam logic [4:0] F_ADD = 5'd1, F_SUB = 5'd2, F_SLL = 5'd3, F_SLT = 5'd4,
                         F_SLTU = 5'd5, F_XOR = 5'd6, F_SRL = 5'd7, F_SRA = 5'd8,
                         F_OR = 5'd9, F_AND = 5'd10, F_EQ = 5'd11, F_NEQ = 5'd12,
                         F_LT = 5'd13, F_GTE = 5'd14, F_LTU = 5'd15, F_GTEU = 5'd16,
                         F_MB = 5'd17, F_MH = 5'd18, F_MW = 5'd19, F_MBU = 5'd20,
                         F_MHU = 5'd21;

  // funct3-indexed function tables; 0 marks an undefined funct3
  localparam logic [4:0] ALU_FN [8] = '{F_ADD, F_SLL, F_SLT, F_SLTU, F_XOR, F_SRL, F_OR, F_AND};
  localparam logic [4:0] BR_FN  [8] = '{F_EQ, F_NEQ, 5'd0, 5'd0, F_LT, F_GTE, F_LTU, F_GTEU};
  localparam logic [4:0] LD_FN  [8] = '{F_MB, F_MH, F_MW, 5'd0, F_MBU, F_MHU, 5'd0, 5'd0};
  localparam logic [4:0] ST_FN  [8] = '{F_MB, F_MH, F_MW, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
  localparam logic [6:0] OPS    [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                         7'h23, 7'h13, 7'h33, 7'h0F};

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  t;
    logic [4:0]  fn;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        is_m;
    logic [2:0]  mop;
    logic        ill;
  } ent_t;

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = '0, in_pc = '0;

  logic o1_in_ready, o1_out_valid, o1_is_m, o1_illegal;
  logic [31:0] o1_pc, o1_imm;
  logic [3:0] o1_type;
  logic [4:0] o1_funct, o1_rd, o1_rs1, o1_rs2;
  logic [2:0] o1_m_op;
  logic o0_in_ready, o0_out_valid, o0_is_m, o0_illegal;
  logic [31:0] o0_pc, o0_imm;
  logic [3:0] o0_type;
  logic [4:0] o0_funct, o0_rd, o0_rs1, o0_rs2;
  logic [2:0] o0_m_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idecoder_pipe #(.DEPTH(DEPTH), .ENABLE_M(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o1_in_ready),
    .inst(inst), .in_pc(in_pc), .out_valid(o1_out_valid), .out_ready(out_ready),
    .out_pc(o1_pc), .inst_type(o1_type), .funct(o1_funct), .imm(o1_imm), .rd(o1_rd),
    .rs1(o1_rs1), .rs2(o1_rs2), .is_m(o1_is_m), .m_op(o1_m_op), .illegal(o1_illegal)
  );

  idecoder_pipe #(.DEPTH(DEPTH), .ENABLE_M(0)) dut_nom (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o0_in_ready),
    .inst(inst), .in_pc(in_pc), .out_valid(o0_out_valid), .out_ready(out_ready),
    .out_pc(o0_pc), .inst_type(o0_type), .funct(o0_funct), .imm(o0_imm), .rd(o0_rd),
    .rs1(o0_rs1), .rs2(o0_rs2), .is_m(o0_is_m), .m_op(o0_m_op), .illegal(o0_illegal)
  );

  function automatic ent_t obs1();
    obs1 = '{pc: o1_pc, t: o1_type, fn: o1_funct, imm: o1_imm, rd: o1_rd, rs1: o1_rs1,
             rs2: o1_rs2, is_m: o1_is_m, mop: o1_m_op, ill: o1_illegal};
  endfunction

  function automatic ent_t obs0();
    obs0 = '{pc: o0_pc, t: o0_type, fn: o0_funct, imm: o0_imm, rd: o0_rd, rs1: o0_rs1,
             rs2: o0_rs2, is_m: o0_is_m, mop: o0_m_op, ill: o0_illegal};
  endfunction

  function automatic ent_t mk(input logic [31:0] pc, input logic [3:0] t, input logic [4:0] fn,
                              input logic [31:0] imm, input int rd, input int rs1, input int rs2,
                              input bit is_m, input int mop, input bit ill);
    mk = '{pc: pc, t: t, fn: fn, imm: imm, rd: 5'(rd), rs1: 5'(rs1), rs2: 5'(rs2),
           is_m: is_m, mop: 3'(mop), ill: ill};
  endfunction

  // Sign-extend the low n bits of v using the xor/subtract identity.
  function automatic logic [31:0] sext(input int n, input logic [31:0] v);
    logic [31:0] m;
    logic [31:0] s;
    m = (32'd1 << n) - 32'd1;
    s = 32'd1 << (n - 1);
    return ((v & m) ^ s) - s;
  endfunction

  function automatic ent_t decode_ref(input logic [31:0] i, input logic [31:0] pc, input bit en_m);
    ent_t e;
    int f3, f7;
    bit bad;
    e = '0;
    e.pc = pc;
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    bad = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin
        e.t = (i[6:0] == 7'h37) ? T_LUI : T_AUIPC;
        e.imm = i & 32'hFFFFF000;
        e.rd = i[11:7];
      end
      7'h6F: begin
        e.t = T_JAL;
        e.imm = sext(21, (32'(i[31]) << 20) | (32'(i[19:12]) << 12) |
                         (32'(i[20]) << 11) | (32'(i[30:21]) << 1));
        e.rd = i[11:7];
      end
      7'h67: begin
        e.t = T_JALR;
        e.imm = sext(12, 32'(i[31:20]));
        e.rd = i[11:7];
        e.rs1 = i[19:15];
      end
      7'h63: begin
        e.t = T_BRANCH;
        e.fn = BR_FN[f3];
        bad = (e.fn == 5'd0);
        e.imm = sext(13, (32'(i[31]) << 12) | (32'(i[7]) << 11) |
                         (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1));
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
      end
      7'h03: begin
        e.t = T_LOAD;
        e.fn = LD_FN[f3];
        bad = (e.fn == 5'd0);
        e.imm = sext(12, 32'(i[31:20]));
        e.rd = i[11:7];
        e.rs1 = i[19:15];
      end
      7'h23: begin
        e.t = T_STORE;
        e.fn = ST_FN[f3];
        bad = (e.fn == 5'd0);
        e.imm = sext(12, (32'(i[31:25]) << 5) | 32'(i[11:7]));
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
      end
      7'h13: begin
        e.t = T_INT_IMM;
        e.fn = ALU_FN[f3];
        e.rd = i[11:7];
        e.rs1 = i[19:15];
        if (f3 == 1 || f3 == 5) begin
          e.imm = 32'(i[24:20]);
          if (f3 == 5 && f7 == 32) e.fn = F_SRA;
          else if (f7 != 0) bad = 1'b1;
        end else begin
          e.imm = sext(12, 32'(i[31:20]));
        end
      end
      7'h33: begin
        e.t = T_INT_REG;
        e.rd = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        if (f7 == 1) begin
          if (en_m) begin
            e.is_m = 1'b1;
            e.mop = i[14:12];
          end else bad = 1'b1;
        end else if (f7 == 0) e.fn = ALU_FN[f3];
        else if (f7 == 32 && f3 == 0) e.fn = F_SUB;
        else if (f7 == 32 && f3 == 5) e.fn = F_SRA;
        else bad = 1'b1;
      end
      7'h0F: e.t = T_FENCE;
      default: bad = 1'b1;
    endcase
    if (bad) begin
      e = '0;
      e.pc = pc;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) r[6:0] = OPS[k];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] i, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    in_valid = v;
    inst = i;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    #1;
  endtask

  task automatic push_one(input logic [31:0] i, input logic [31:0] pc);
    drive(1'b1, i, pc, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #20;
    checks++;
    if (o1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", o1_out_valid); end
    checks++;
    if (obs1() !== ent_t'('0)) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", obs1()); end
    rst = 1'b1;
    tick();
    checks++;
    if (o1_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", o1_in_ready); end
    checks++;
    if (o1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_out_valid: got %b expected 0", o1_out_valid); end
    checks++;
    if (obs1() !== ent_t'('0)) begin errors++; $display("[TB] FAIL release_data: got %h expected 0", obs1()); end
  endtask

  task automatic test_addi();
    push_one(32'h00500093, 32'h100);
    checks++;
    if (o1_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL addi_valid: got %b expected 1", o1_out_valid); end
    checks++;
    if (obs1() !== mk(32'h100, T_INT_IMM, F_ADD, 32'd5, 1, 0, 0, 0, 0, 0))
      begin errors++; $display("[TB] FAIL addi_fields: got %h expected %h", obs1(), mk(32'h100, T_INT_IMM, F_ADD, 32'd5, 1, 0, 0, 0, 0, 0)); end
    pop_one();
    checks++;
    if (o1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL addi_popped: got %b expected 0", o1_out_valid); end
  endtask

  task automatic test_shift();
    push_one(32'h4041D113, 32'h104);
    checks++;
    if (obs1() !== mk(32'h104, T_INT_IMM, F_SRA, 32'd4, 2, 3, 0, 0, 0, 0))
      begin errors++; $display("[TB] FAIL srai_fields: got %h expected %h", obs1(), mk(32'h104, T_INT_IMM, F_SRA, 32'd4, 2, 3, 0, 0, 0, 0)); end
    pop_one();
    push_one(32'h2041D113, 32'h108);
    checks++;
    if (obs1() !== mk(32'h108, 4'd0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 1))
      begin errors++; $display("[TB] FAIL bad_shift_funct7: got %h expected %h", obs1(), mk(32'h108, 4'd0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 1)); end
    pop_one();
  endtask

  task automatic test_mul();
    push_one(32'h027302B3, 32'h10C);
    checks++;
    if (obs1() !== mk(32'h10C, T_INT_REG, 5'd0, 32'd0, 5, 6, 7, 1, 0, 0))
      begin errors++; $display("[TB] FAIL mul_m_on: got %h expected %h", obs1(), mk(32'h10C, T_INT_REG, 5'd0, 32'd0, 5, 6, 7, 1, 0, 0)); end
    checks++;
    if (obs0() !== mk(32'h10C, 4'd0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 1))
      begin errors++; $display("[TB] FAIL mul_m_off: got %h expected %h", obs0(), mk(32'h10C, 4'd0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 1)); end
    pop_one();
    push_one(32'h027372B3, 32'h110);
    checks++;
    if (obs1() !== mk(32'h110, T_INT_REG, 5'd0, 32'd0, 5, 6, 7, 1, 7, 0))
      begin errors++; $display("[TB] FAIL remu_m_op: got %h expected %h", obs1(), mk(32'h110, T_INT_REG, 5'd0, 32'd0, 5, 6, 7, 1, 7, 0)); end
    pop_one();
  endtask

  task automatic test_full_order();
    drive(1'b1, 32'h123450B7, 32'h200, 1'b0, 1'b0);
    tick();
    checks++;
    if (o1_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL one_entry_ready: got %b expected 1", o1_in_ready); end
    drive(1'b1, 32'h00500093, 32'h204, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00A00113, 32'h208, 1'b1, 1'b0);
    checks++;
    if (o1_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_not_ready: got %b expected 0", o1_in_ready); end
    checks++;
    if (obs1() !== mk(32'h200, T_LUI, 5'd0, 32'h12345000, 1, 0, 0, 0, 0, 0))
      begin errors++; $display("[TB] FAIL lui_first: got %h expected %h", obs1(), mk(32'h200, T_LUI, 5'd0, 32'h12345000, 1, 0, 0, 0, 0, 0)); end
    tick();
    checks++;
    if (obs1() !== mk(32'h204, T_INT_IMM, F_ADD, 32'd5, 1, 0, 0, 0, 0, 0))
      begin errors++; $display("[TB] FAIL addi_second: got %h expected %h", obs1(), mk(32'h204, T_INT_IMM, F_ADD, 32'd5, 1, 0, 0, 0, 0, 0)); end
    checks++;
    if (o1_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL after_pop_ready: got %b expected 1", o1_in_ready); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (obs1() !== mk(32'h208, T_INT_IMM, F_ADD, 32'd10, 2, 0, 0, 0, 0, 0))
      begin errors++; $display("[TB] FAIL third_entry: got %h expected %h", obs1(), mk(32'h208, T_INT_IMM, F_ADD, 32'd10, 2, 0, 0, 0, 0, 0)); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (o1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drained: got %b expected 0", o1_out_valid); end
  endtask

  task automatic test_flush();
    push_one(32'h123450B7, 32'h300);
    push_one(32'h00500093, 32'h304);
    drive(1'b1, 32'h00A00113, 32'h308, 1'b1, 1'b1);
    checks++;
    if (o1_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_blocks_push: got %b expected 0", o1_in_ready); end
    checks++;
    if (o1_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_flush_valid: got %b expected 1", o1_out_valid); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (o1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empties: got %b expected 0", o1_out_valid); end
    checks++;
    if (o1_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_flush_ready: got %b expected 1", o1_in_ready); end
    checks++;
    if (obs1() !== ent_t'('0)) begin errors++; $display("[TB] FAIL post_flush_data: got %h expected 0", obs1()); end
    push_one(32'h00500093, 32'h30C);
    checks++;
    if (obs1() !== mk(32'h30C, T_INT_IMM, F_ADD, 32'd5, 1, 0, 0, 0, 0, 0))
      begin errors++; $display("[TB] FAIL post_flush_push: got %h expected %h", obs1(), mk(32'h30C, T_INT_IMM, F_ADD, 32'd5, 1, 0, 0, 0, 0, 0)); end
    pop_one();
    checks++;
    if (o1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_flush_alone: got %b expected 0", o1_out_valid); end
  endtask

  task automatic test_async_reset();
    push_one(32'h123450B7, 32'h400);
    push_one(32'h00500093, 32'h404);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (o1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_valid: got %b expected 0", o1_out_valid); end
    checks++;
    if (obs1() !== ent_t'('0)) begin errors++; $display("[TB] FAIL async_reset_data: got %h expected 0", obs1()); end
    checks++;
    if (o0_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_valid_nom: got %b expected 0", o0_out_valid); end
    #1;
    rst = 1'b1;
    tick();
    checks++;
    if (o1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL no_stale_entry: got %b expected 0", o1_out_valid); end
  endtask

  task automatic test_illegal();
    push_one(32'h0000007F, 32'h408);
    checks++;
    if (obs1() !== mk(32'h408, 4'd0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 1))
      begin errors++; $display("[TB] FAIL illegal_opcode: got %h expected %h", obs1(), mk(32'h408, 4'd0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 1)); end
    pop_one();
  endtask

  task automatic test_random();
    ent_t q1[$];
    ent_t q0[$];
    bit exp_ready, push, pop;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, gen_inst(), $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
      exp_ready = (q1.size() < DEPTH) && !flush;
      checks++;
      if (o1_in_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand_in_ready cyc %0d: got %b expected %b", c, o1_in_ready, exp_ready); end
      checks++;
      if (o1_out_valid !== (q1.size() != 0)) begin errors++; $display("[TB] FAIL rand_out_valid cyc %0d: got %b expected %b", c, o1_out_valid, q1.size() != 0); end
      checks++;
      if (obs1() !== ((q1.size() != 0) ? q1[0] : ent_t'('0)))
        begin errors++; $display("[TB] FAIL rand_head cyc %0d: got %h expected %h", c, obs1(), (q1.size() != 0) ? q1[0] : ent_t'('0)); end
      checks++;
      if (obs0() !== ((q0.size() != 0) ? q0[0] : ent_t'('0)))
        begin errors++; $display("[TB] FAIL rand_head_nom cyc %0d: got %h expected %h", c, obs0(), (q0.size() != 0) ? q0[0] : ent_t'('0)); end
      checks++;
      if (o0_in_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand_in_ready_nom cyc %0d: got %b expected %b", c, o0_in_ready, exp_ready); end
      push = in_valid && exp_ready;
      pop = out_ready && (q1.size() != 0);
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (pop) begin
          void'(q1.pop_front());
          void'(q0.pop_front());
        end
        if (push) begin
          q1.push_back(decode_ref(inst, in_pc, 1'b1));
          q0.push_back(decode_ref(inst, in_pc, 1'b0));
        end
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_shift();
    test_mul();
    test_full_order();
    test_flush();
    test_async_reset();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
